// File: rtl/serial_rx.sv
// Oversampling asynchronous serial receiver (8N1). Define SERIAL_RX_PARITY_EN
// to add an even-parity bit between data bit 7 and the stop bit.
module serial_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_o,
  output logic       data_ready_o,
  input  logic       data_clear_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DIV = (CLK_FREQ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVS);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_nxt;
  logic            rxd_meta, rxd_sync, rxd_prev;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   samp_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            break_wait;
  logic            tick, samp_hit, fall_edge, complete, frame_bad;
`ifdef SERIAL_RX_PARITY_EN
  logic            par_bad;
`endif

  assign tick      = (tick_cnt == TW'(DIV - 1));
  assign fall_edge = rxd_prev & ~rxd_sync;
  // START samples at the half-bit point; every later state samples a full bit on.
  assign samp_hit  = tick && (samp_cnt == ((state == START) ? SW'(OVS / 2 - 1) : SW'(OVS - 1)));
  assign complete  = (state == STOP) && samp_hit;
`ifdef SERIAL_RX_PARITY_EN
  assign frame_bad = ~rxd_sync | par_bad;
`else
  assign frame_bad = ~rxd_sync;
`endif
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      tick_cnt <= '0;
      state    <= IDLE;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      state    <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (fall_edge && !break_wait) state_nxt = START;
      START:  if (samp_hit) state_nxt = rxd_sync ? IDLE : DATA;
`ifdef SERIAL_RX_PARITY_EN
      DATA:   if (samp_hit && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY: if (samp_hit) state_nxt = STOP;
`else
      DATA:   if (samp_hit && bit_cnt == 3'd7) state_nxt = STOP;
`endif
      STOP:   if (samp_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      break_wait   <= 1'b0;
      data_o       <= '0;
      data_ready_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad      <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        samp_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        samp_cnt <= samp_hit ? '0 : samp_cnt + 1'b1;
      end

      if (state == DATA && samp_hit) begin
        shift_reg <= {rxd_sync, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end

`ifdef SERIAL_RX_PARITY_EN
      if (state == PARITY && samp_hit)
        par_bad <= (rxd_sync != ^shift_reg);
`endif

      // A line stuck low after a bad frame must return high before a new start edge counts.
      if (state == IDLE && rxd_sync)
        break_wait <= 1'b0;

      if (data_clear_i) begin
        data_ready_o <= 1'b0;
        frame_err_o  <= 1'b0;
        overrun_o    <= 1'b0;
      end

      // Completion overrides a coincident clear so the fresh byte and its status survive.
      if (complete) begin
        if (!data_ready_o || data_clear_i) begin
          data_o       <= shift_reg;
          data_ready_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
        if (frame_bad) begin
          frame_err_o <= 1'b1;
          break_wait  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: directed frames push expected bytes, a monitor
// checks each byte as data_ready_o rises. Honors SERIAL_RX_PARITY_EN.
module tb_serial_rx;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int OVS      = 16;
  localparam int DIV      = 27;
  localparam int BIT      = DIV * OVS;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_BITS_X2 = 21;
`else
  localparam int FRAME_BITS_X2 = 19;
`endif
  // Mid-stop-bit deadline, plus synchronizer and tick-phase slack.
  localparam int READY_LIMIT = (BIT * FRAME_BITS_X2) / 2 + 2 * DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       data_clear_i = 1'b0;
  logic [7:0] data_o;
  logic       data_ready_o, frame_err_o, overrun_o, busy_o;

  exp_t sb_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  logic ready_q   = 1'b0;

  serial_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .data_o       (data_o),
    .data_ready_o (data_ready_o),
    .data_clear_i (data_clear_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expectByte(input logic [7:0] d, input logic fe);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    sb_q.push_back(e);
  endtask

  // One idle bit, then start, 8 data bits LSB first, optional parity, stop.
  task automatic applyStimulus(input logic [7:0] d, input logic stop, input logic par_flip);
    rxd = 1'b1;
    repeat (BIT) @(posedge clk);
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    repeat (BIT) @(posedge clk);
`else
    if (par_flip) $display("[TB] parity flip ignored in 8N1 build");
`endif
    rxd = stop;
    repeat (BIT) @(posedge clk);
    if (!stop) repeat (BIT / 2) @(posedge clk);
    rxd = 1'b1;
  endtask

  task automatic pulseClear();
    @(negedge clk) data_clear_i = 1'b1;
    @(negedge clk) data_clear_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (cycles < 2 * READY_LIMIT && !data_ready_o) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Monitor: compare each newly presented byte against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && data_ready_o && !ready_q) begin
      if (sb_q.size() == 0) begin
        check_cnt++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", data_o);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_data", data_o, e.data);
        checkOutput("sb_frame_err", frame_err_o, e.fe);
      end
    end
    ready_q = data_ready_o;
  end

  initial begin
    int cyc;
    repeat (5) @(negedge clk);
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_ready", data_ready_o, 0);
    checkOutput("rst_frame_err", frame_err_o, 0);
    checkOutput("rst_overrun", overrun_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] byte 0x55");
    expectByte(8'h55, 1'b0);
    fork
      applyStimulus(8'h55, 1'b1, 1'b0);
      begin
        repeat (BIT) @(posedge clk);
        waitReady(cyc);
        checkOutput("t55_in_time", int'(data_ready_o && cyc <= READY_LIMIT), 1);
      end
    join
    checkOutput("t55_frame_err", frame_err_o, 0);
    pulseClear();
    checkOutput("t55_cleared", data_ready_o, 0);

    $display("[TB] overrun 0xA3 then 0x3C");
    expectByte(8'hA3, 1'b0);
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ovr_data", data_o, 8'hA3);
    checkOutput("ovr_flag", overrun_o, 1);
    checkOutput("ovr_ready", data_ready_o, 1);
    pulseClear();
    checkOutput("ovr_clr_ready", data_ready_o, 0);
    checkOutput("ovr_clr_overrun", overrun_o, 0);
    checkOutput("ovr_clr_frame_err", frame_err_o, 0);

    $display("[TB] bad stop 0x7E then 0x01");
    expectByte(8'h7E, 1'b1);
    applyStimulus(8'h7E, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fe_flag", frame_err_o, 1);
    pulseClear();
    checkOutput("fe_cleared", frame_err_o, 0);
    expectByte(8'h01, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("fe_next_data", data_o, 8'h01);
    checkOutput("fe_next_ready", data_ready_o, 1);
    pulseClear();

    $display("[TB] glitch");
    rxd = 1'b0;
    repeat (100) @(posedge clk);
    rxd = 1'b1;
    @(negedge clk);
    checkOutput("glitch_busy_during", busy_o, 1);
    repeat (BIT) @(negedge clk);
    checkOutput("glitch_busy_after", busy_o, 0);
    checkOutput("glitch_ready", data_ready_o, 0);
    checkOutput("glitch_frame_err", frame_err_o, 0);

    $display("[TB] reset in bit 4 of 0xFF");
    repeat (BIT) @(posedge clk);
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    rxd = 1'b1;
    repeat (4 * BIT + BIT / 2) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_busy_before", busy_o, 1);
    #2 rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_data", data_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_ready", data_ready_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * BIT) @(posedge clk);
    checkOutput("mid_rst_idle", busy_o, 0);
    expectByte(8'h12, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mid_next_data", data_o, 8'h12);
    pulseClear();

`ifdef SERIAL_RX_PARITY_EN
    $display("[TB] bad parity 0x07");
    expectByte(8'h07, 1'b1);
    applyStimulus(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("par_data", data_o, 8'h07);
    checkOutput("par_frame_err", frame_err_o, 1);
    pulseClear();
`endif

    repeat (BIT) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 SHALL have parameter OVS, default 16, meaning samples per bit (power of two, at least 8).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port data_o, output, 8 bits: last received byte, LSB first on the line.
REQ-008 SHALL have port data_ready_o, output, 1 bit: a byte is held in data_o and not yet consumed.
REQ-009 SHALL have port data_clear_i, input, 1 bit: consume pulse from the CPU serial port logic.
REQ-010 SHALL have port frame_err_o, output, 1 bit: sticky; the last frame had a bad stop bit (or bad parity, see Configuration).
REQ-011 SHALL have port overrun_o, output, 1 bit: sticky; a byte was lost because data_ready_o was still set.
REQ-012 SHALL have port busy_o, output, 1 bit: a frame is in progress.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer, with flops reset to 1, before any use.
REQ-014 SHALL generate a sample tick once every DIV clocks, where DIV = CLK_FREQ/(BAUD*OVS) rounded to nearest; the tick counter runs freely.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, with PARITY added only when the Configuration macro is defined.
- IDLE to START on a synchronized rxd falling edge; the sample counter clears.
REQ-016 SHALL, in START, sample at tick OVS/2.
- Sampled 1: false start, return to IDLE, no flags change.
- Sampled 0: go to DATA.
REQ-017 SHALL, in DATA, sample every OVS ticks from the mid-bit point and shift right into an 8-bit register, LSB first; go to STOP after the 8th bit.
REQ-018 SHALL, at the STOP-bit mid-sample, update outputs in the same cycle and then return to IDLE:
- load data_o;
- set data_ready_o;
- set frame_err_o if the sampled stop bit is 0.
REQ-019 SHALL hold data_o stable while data_ready_o is 1.
- A byte completing while data_ready_o is 1 is discarded; data_o keeps its old value and overrun_o is set.
REQ-020 SHALL clear data_ready_o, frame_err_o and overrun_o on the cycle after data_clear_i is sampled high.
- If completion and data_clear_i coincide, the new byte loads and data_ready_o stays 1; no overrun.
REQ-021 SHALL assert busy_o in every state except IDLE.
REQ-022 SHALL, when a frame error occurs, wait in IDLE for rxd to be sampled high before accepting the next falling edge (break handling).

Reset
REQ-023 SHALL, while rst_n is 0, force the following regardless of clk:
- data_o = 0x00;
- data_ready_o, frame_err_o, overrun_o and busy_o = 0;
- state = IDLE;
- all counters = 0.
REQ-024 SHALL, on reset mid-frame, discard the partial byte; after release, reception starts only on a fresh falling edge.

Configuration
REQ-025 SHALL compile the PARITY state only when macro SERIAL_RX_PARITY_EN is defined.
- Defined: one even-parity bit between bit 7 and the stop bit; a mismatch sets frame_err_o, and the byte is still delivered.
- Not defined: 8N1 framing; no parity logic is present.

Verification
REQ-026 SHALL cover the following directed scenarios (defaults: DIV = 27, bit time 432 clocks):
- Send 0x55 (8N1). Expected: data_o = 0x55 and data_ready_o = 1 within 9.5 bit times of the start edge, frame_err_o = 0.
- Send 0xA3, then 0x3C without asserting data_clear_i. Expected: data_o = 0xA3, overrun_o = 1; after data_clear_i, all three flags are 0.
- Send 0x7E with stop bit forced to 0, then release the line high and send 0x01. Expected: frame_err_o = 1 on 0x7E; 0x01 is received correctly after clearing.
- Hold rxd low for 100 clocks, then high (glitch). Expected: state returns to IDLE, busy_o falls, data_ready_o = 0.
- Assert rst_n = 0 in the middle of bit 4 of 0xFF. Expected: outputs are 0 immediately; the next 0x12 is received correctly.
- With SERIAL_RX_PARITY_EN, send 0x07 with parity 0 (wrong). Expected: data_o = 0x07 and frame_err_o = 1.
